// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32 core.
// Define SEQ_TIMEOUT_EN to trap when a memory ack does not arrive within TIMEOUT_CYCLES.
module stage_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_i,
    input  logic [31:0] ir_i,
    output logic [2:0]  stage_o,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    output logic        ir_we_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic        wd_q_o,
    output logic        pc_we_o,
    output logic [31:0] retired_o,
    output logic        halted_o,
    output logic [1:0]  err_code_o
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [1:0] ERR_ILLEGAL = 2'd1;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("stage_sequencer: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic [1:0]  err_q, err_d;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [1:0]  ERR_TIMEOUT = 2'd2;
    localparam logic [15:0] WAIT_LIMIT  = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_q, wait_d;
`endif

    logic [6:0] opcode;
    logic       is_load, is_store, is_legal, rd_nz;
    logic       unused_ir;

    assign opcode    = ir_i[6:0];
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_legal  = is_load || is_store || (opcode == OPC_OP) ||
                       (opcode == OPC_OP_IMM) || (opcode == OPC_LUI);
    assign rd_nz     = (ir_i[11:7] != 5'd0);
    assign unused_ir = ^ir_i[31:12];

    logic imem_req, ir_we, dmem_req, dmem_we, wd, pc_we;

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        err_d     = err_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        wd        = 1'b0;
        pc_we     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        wait_d    = wait_q;
`endif
        case (state_q)
            ST_FETCH: begin
                imem_req = run_i;
                if (run_i && imem_ack_i) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
`ifdef SEQ_TIMEOUT_EN
                // The wait count only runs while a fetch is actually requested.
                if (!run_i) begin
                    wait_d = '0;
                end else if (!imem_ack_i) begin
                    if (wait_q == WAIT_LIMIT) begin
                        state_d = ST_TRAP;
                        err_d   = ERR_TIMEOUT;
                    end else begin
                        wait_d = wait_q + 16'd1;
                    end
                end
`endif
            end
            ST_DECODE: begin
                if (is_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    err_d   = ERR_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (is_load || is_store) begin
                    state_d = ST_MEM;
`ifdef SEQ_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack_i) begin
                    if (is_store) begin
                        // Stores retire in the ack cycle; no write-back stage.
                        pc_we     = 1'b1;
                        retired_d = retired_q + 32'd1;
                        state_d   = ST_FETCH;
`ifdef SEQ_TIMEOUT_EN
                        wait_d    = '0;
`endif
                    end else begin
                        state_d = ST_WB;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_q == WAIT_LIMIT) begin
                    state_d = ST_TRAP;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
`endif
            end
            ST_WB: begin
                pc_we     = 1'b1;
                wd        = rd_nz;
                retired_d = retired_q + 32'd1;
                state_d   = ST_FETCH;
`ifdef SEQ_TIMEOUT_EN
                wait_d    = '0;
`endif
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
            err_q     <= '0;
`ifdef SEQ_TIMEOUT_EN
            wait_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            err_q     <= err_d;
`ifdef SEQ_TIMEOUT_EN
            wait_q    <= wait_d;
`endif
        end
    end

    // Requests and strobes are forced low for the whole time reset is held.
    assign imem_req_o = imem_req & ~reset;
    assign ir_we_o    = ir_we    & ~reset;
    assign dmem_req_o = dmem_req & ~reset;
    assign dmem_we_o  = dmem_we  & ~reset;
    assign wd_q_o     = wd       & ~reset;
    assign pc_we_o    = pc_we    & ~reset;

    assign stage_o    = state_q;
    assign retired_o  = retired_q;
    assign halted_o   = (state_q == ST_TRAP);
    assign err_code_o = err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: a per-cycle expectation queue built from the
// instruction-level rules, checked every cycle, plus literal spot checks.
module tb_stage_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_i;
    logic [31:0] ir_i;
    logic [2:0]  stage_o;
    logic        imem_req_o, imem_ack_i, ir_we_o;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic        wd_q_o, pc_we_o, halted_o;
    logic [31:0] retired_o;
    logic [1:0]  err_code_o;

    always #5 clk = ~clk;

    stage_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .run_i      (run_i),
        .ir_i       (ir_i),
        .stage_o    (stage_o),
        .imem_req_o (imem_req_o),
        .imem_ack_i (imem_ack_i),
        .ir_we_o    (ir_we_o),
        .dmem_req_o (dmem_req_o),
        .dmem_we_o  (dmem_we_o),
        .dmem_ack_i (dmem_ack_i),
        .wd_q_o     (wd_q_o),
        .pc_we_o    (pc_we_o),
        .retired_o  (retired_o),
        .halted_o   (halted_o),
        .err_code_o (err_code_o)
    );

    typedef struct packed {
        logic        run;
        logic        iack;
        logic        dack;
        logic [31:0] ir;
        logic [2:0]  st;
        logic        imreq;
        logic        irwe;
        logic        dreq;
        logic        dwe;
        logic        wd;
        logic        pcwe;
        logic        halt;
        logic [1:0]  err;
        logic [31:0] ret;
    } cyc_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    cyc_t        q[$];
    cyc_t        cur;
    logic        chk_en = 1'b0;
    logic [31:0] m_ret = '0;
    logic [1:0]  m_err = '0;
    logic [31:0] g_ir = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stage",    32'(stage_o),    32'(cur.st));
            chk("imem_req", 32'(imem_req_o), 32'(cur.imreq));
            chk("ir_we",    32'(ir_we_o),    32'(cur.irwe));
            chk("dmem_req", 32'(dmem_req_o), 32'(cur.dreq));
            chk("dmem_we",  32'(dmem_we_o),  32'(cur.dwe));
            chk("wd_q",     32'(wd_q_o),     32'(cur.wd));
            chk("pc_we",    32'(pc_we_o),    32'(cur.pcwe));
            chk("halted",   32'(halted_o),   32'(cur.halt));
            chk("err_code", 32'(err_code_o), 32'(cur.err));
            chk("retired",  retired_o,       cur.ret);
        end
    end

    // Default cycle: stray acks on both ports, which must be ignored unless handshaking.
    function automatic cyc_t mk(input logic [2:0] st);
        cyc_t c;
        c      = '0;
        c.run  = 1'b1;
        c.iack = 1'b1;
        c.dack = 1'b1;
        c.ir   = g_ir;
        c.st   = st;
        c.halt = (st == 3'd7);
        c.err  = m_err;
        c.ret  = m_ret;
        return c;
    endfunction

    task automatic gen_trap(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = mk(3'd7);
            q.push_back(c);
        end
    endtask

    task automatic gen_idle(input int n, input logic iack, input logic dack);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c      = mk(3'd0);
            c.run  = 1'b0;
            c.iack = iack;
            c.dack = dack;
            q.push_back(c);
        end
    endtask

    task automatic gen_instr(input logic [31:0] ir, input int fdly, input int mdly,
                             input logic run_after);
        cyc_t       c;
        logic [6:0] opc;
        logic       ld, st, legal;
        g_ir  = ir;
        opc   = ir[6:0];
        ld    = (opc == 7'b0000011);
        st    = (opc == 7'b0100011);
        legal = ld || st || (opc == 7'b0110011) || (opc == 7'b0010011) || (opc == 7'b0110111);
`ifdef SEQ_TIMEOUT_EN
        if (fdly >= TO) begin
            for (int i = 0; i < TO; i++) begin
                c = mk(3'd0); c.iack = 1'b0; c.imreq = 1'b1; q.push_back(c);
            end
            m_err = 2'd2;
            gen_trap(3);
            return;
        end
`endif
        for (int i = 0; i < fdly; i++) begin
            c = mk(3'd0); c.iack = 1'b0; c.imreq = 1'b1; q.push_back(c);
        end
        c = mk(3'd0); c.imreq = 1'b1; c.irwe = 1'b1; q.push_back(c);
        c = mk(3'd1); c.run = run_after; q.push_back(c);
        if (!legal) begin
            m_err = 2'd1;
            gen_trap(3);
            return;
        end
        c = mk(3'd2); c.run = run_after; q.push_back(c);
        if (ld || st) begin
`ifdef SEQ_TIMEOUT_EN
            if (mdly >= TO) begin
                for (int i = 0; i < TO; i++) begin
                    c = mk(3'd3); c.run = run_after; c.dack = 1'b0;
                    c.dreq = 1'b1; c.dwe = st; q.push_back(c);
                end
                m_err = 2'd2;
                gen_trap(3);
                return;
            end
`endif
            for (int i = 0; i < mdly; i++) begin
                c = mk(3'd3); c.run = run_after; c.dack = 1'b0;
                c.dreq = 1'b1; c.dwe = st; q.push_back(c);
            end
            c = mk(3'd3); c.run = run_after; c.dreq = 1'b1; c.dwe = st; c.pcwe = st;
            q.push_back(c);
            if (st) begin
                m_ret = m_ret + 32'd1;
                return;
            end
        end
        c = mk(3'd4); c.run = run_after; c.pcwe = 1'b1; c.wd = (ir[11:7] != 5'd0);
        q.push_back(c);
        m_ret = m_ret + 32'd1;
    endtask

    task automatic drive_one();
        cur        = q.pop_front();
        run_i      = cur.run;
        ir_i       = cur.ir;
        imem_ack_i = cur.iack;
        dmem_ack_i = cur.dack;
        chk_en     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic play();
        while (q.size() > 0) drive_one();
        chk_en = 1'b0;
    endtask

    task automatic play_n(input int n);
        for (int i = 0; i < n && q.size() > 0; i++) drive_one();
        q.delete();
        chk_en = 1'b0;
    endtask

    // Entered at posedge+1; asserts reset mid-cycle with run and acks high.
    task automatic do_reset(input string tag);
        #2;
        run_i      = 1'b1;
        imem_ack_i = 1'b1;
        dmem_ack_i = 1'b1;
        reset      = 1'b1;
        #1;
        chk({tag, "_imem_req"}, 32'(imem_req_o), 32'd0);
        chk({tag, "_ir_we"},    32'(ir_we_o),    32'd0);
        chk({tag, "_dmem_req"}, 32'(dmem_req_o), 32'd0);
        chk({tag, "_pc_we"},    32'(pc_we_o),    32'd0);
        chk({tag, "_stage"},    32'(stage_o),    32'd0);
        chk({tag, "_retired"},  retired_o,       32'd0);
        chk({tag, "_err"},      32'(err_code_o), 32'd0);
        chk({tag, "_halted"},   32'(halted_o),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ret = '0;
        m_err = '0;
    endtask

    initial begin
        reset      = 1'b1;
        run_i      = 1'b1;
        ir_i       = '0;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        #3;
        chk("rst0_imem_req", 32'(imem_req_o), 32'd0);
        chk("rst0_stage",    32'(stage_o),    32'd0);
        chk("rst0_retired",  retired_o,       32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADDI x5: 4-cycle ALU path
        gen_instr(32'h0050_0293, 0, 0, 1'b1);
        play();
        chk("addi_retired", retired_o, 32'd1);

        // LW x6 with dmem ack after 3 wait cycles
        gen_instr(32'h0000_A303, 0, 3, 1'b1);
        play();
        chk("lw_retired", retired_o, 32'd2);

        // SW with one fetch wait cycle
        gen_instr(32'h0060_A023, 1, 0, 1'b1);
        play();
        chk("sw_retired", retired_o, 32'd3);

        gen_idle(3, 1'b1, 1'b1);
        // ADD x0 with run_i dropped right after fetch: completes, then idles
        gen_instr(32'h0000_0033, 0, 0, 1'b0);
        gen_idle(2, 1'b1, 1'b0);
        play();
        chk("add_x0_retired", retired_o, 32'd4);

`ifdef SEQ_TIMEOUT_EN
        // Ack on the last allowed cycle wins over the timeout
        gen_instr(32'h0060_A023, TO - 1, 0, 1'b1);
        gen_instr(32'h0000_A303, 0, TO - 1, 1'b1);
`else
        // Without the timeout, long waits never trap
        gen_instr(32'h0060_A023, 9, 0, 1'b1);
        gen_instr(32'h0000_A303, 0, 12, 1'b1);
`endif
        play();
        chk("long_wait_retired", retired_o, 32'd6);
        chk("long_wait_halted", 32'(halted_o), 32'd0);

        // Counter wrap
        run_i = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFF_FFFF;
        chk("wrap_preload", retired_o, 32'hFFFF_FFFF);
        gen_instr(32'h0000_0033, 0, 0, 1'b1);
        play();
        chk("wrap_retired", retired_o, 32'd0);

        // Illegal opcode traps and stays
        gen_instr(32'h0000_007F, 0, 0, 1'b1);
        gen_trap(4);
        play();
        chk("trap_stage",  32'(stage_o),    32'd7);
        chk("trap_halted", 32'(halted_o),   32'd1);
        chk("trap_err",    32'(err_code_o), 32'd1);
        chk("trap_ret",    retired_o,       32'd0);
        do_reset("rst1");

        // Reset in the middle of a MEM wait abandons the request
        gen_instr(32'h0000_A303, 0, 5, 1'b1);
        play_n(5);
        run_i      = 1'b0;
        dmem_ack_i = 1'b0;
        #1;
        chk("midmem_stage",    32'(stage_o),    32'd3);
        chk("midmem_dmem_req", 32'(dmem_req_o), 32'd1);
        reset = 1'b1;
        #1;
        chk("midmem_rst_dmem_req", 32'(dmem_req_o), 32'd0);
        chk("midmem_rst_stage",    32'(stage_o),    32'd0);
        dmem_ack_i = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ret = '0;
        m_err = '0;
        gen_idle(2, 1'b0, 1'b1);
        play();

`ifdef SEQ_TIMEOUT_EN
        gen_instr(32'h0050_0293, TO + 6, 0, 1'b1);
        play();
        chk("fetch_to_err",    32'(err_code_o), 32'd2);
        chk("fetch_to_halted", 32'(halted_o),   32'd1);
        do_reset("rst2");
        gen_instr(32'h0000_A303, 0, TO + 6, 1'b1);
        play();
        chk("mem_to_err", 32'(err_code_o), 32'd2);
        do_reset("rst3");
`endif

        gen_instr(32'h0050_0293, 0, 0, 1'b1);
        play();
        chk("final_retired", retired_o, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
